// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the two writeback sources (ALU, load return) sharing
// the register file's single write port; writes to the zero register are swallowed and counted.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Valid0,
    input  logic [ADDR_WIDTH-1:0] Addr0,
    input  logic [DATA_WIDTH-1:0] Data0,
    output logic                  Ready0,
    input  logic                  Valid1,
    input  logic [ADDR_WIDTH-1:0] Addr1,
    input  logic [DATA_WIDTH-1:0] Data1,
    output logic                  Ready1,
    output logic [ADDR_WIDTH-1:0] RW,
    output logic [DATA_WIDTH-1:0] BusW,
    output logic                  RegWr,
    output logic [CNT_WIDTH-1:0]  DropCount
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic                  prio_q, prio_d;
    logic                  regwr_q, regwr_d;
    logic [ADDR_WIDTH-1:0] rw_q, rw_d;
    logic [DATA_WIDTH-1:0] busw_q, busw_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

    logic                  ready0, ready1, xfer, drop;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    always_comb begin
        // Grants depend only on valids, pointer and reset; address/data never gate Ready.
        ready0   = ~Reset & Valid0 & (~Valid1 | ~prio_q);
        ready1   = ~Reset & Valid1 & (~Valid0 |  prio_q);
        win_addr = ready1 ? Addr1 : Addr0;
        win_data = ready1 ? Data1 : Data0;
        xfer     = ready0 | ready1;
        drop     = xfer & (win_addr == ZERO_ADDR);

        prio_d = prio_q;
        if (ready0)
            prio_d = 1'b1;
        else if (ready1)
            prio_d = 1'b0;

        regwr_d = xfer & ~drop;
        rw_d    = rw_q;
        busw_d  = busw_q;
        if (regwr_d) begin
            rw_d   = win_addr;
            busw_d = win_data;
        end

        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != {CNT_WIDTH{1'b1}}))
            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prio_q     <= 1'b0;
            regwr_q    <= 1'b0;
            rw_q       <= '0;
            busw_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            prio_q     <= prio_d;
            regwr_q    <= regwr_d;
            rw_q       <= rw_d;
            busw_q     <= busw_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign Ready0    = ready0;
    assign Ready1    = ready1;
    assign RegWr     = regwr_q;
    assign RW        = rw_q;
    assign BusW      = busw_q;
    assign DropCount = drop_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued at grant
// time and popped when the write port strobes; a small register file commits on negedge.
module tb_regfile_write_arbiter;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } wr_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Valid0, Valid1;
    logic [4:0]  Addr0, Addr1;
    logic [63:0] Data0, Data1;
    logic        Ready0, Ready1, RegWr;
    logic [4:0]  RW;
    logic [63:0] BusW;
    logic [7:0]  DropCount;

    logic        Ready0_s, Ready1_s, RegWr_s;
    logic [4:0]  RW_s;
    logic [63:0] BusW_s;
    logic [1:0]  DropCount_s;

    logic [63:0] regs [32];
    wr_t         exp_q [$];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    regfile_write_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .Valid0(Valid0), .Addr0(Addr0), .Data0(Data0), .Ready0(Ready0),
        .Valid1(Valid1), .Addr1(Addr1), .Data1(Data1), .Ready1(Ready1),
        .RW(RW), .BusW(BusW), .RegWr(RegWr), .DropCount(DropCount)
    );

    regfile_write_arbiter #(.CNT_WIDTH(2)) dut_sat (
        .Clk(Clk), .Reset(Reset),
        .Valid0(Valid0), .Addr0(Addr0), .Data0(Data0), .Ready0(Ready0_s),
        .Valid1(Valid1), .Addr1(Addr1), .Data1(Data1), .Ready1(Ready1_s),
        .RW(RW_s), .BusW(BusW_s), .RegWr(RegWr_s), .DropCount(DropCount_s)
    );

    always #5 Clk = ~Clk;

    initial for (int i = 0; i < 32; i++) regs[i] = '0;
    always @(negedge Clk) if (RegWr) regs[RW] <= BusW;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1; Valid0 = 1'b0; Valid1 = 1'b0;
        tick();
        Reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        Reset = 1'b1; Valid0 = 1'b1; Valid1 = 1'b1;
        Addr0 = 5'd3; Addr1 = 5'd4; Data0 = 64'h11; Data1 = 64'h22;
        #1;
        total_cnt++;
        if ({Ready0, Ready1} !== 2'b00) $display("FAIL reset_ready got=%b want=00", {Ready0, Ready1});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({RegWr, RW, BusW, DropCount} !== '0)
            $display("FAIL reset_state got regwr=%b rw=%0d busw=%h drop=%0d want all 0", RegWr, RW, BusW, DropCount);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({Ready0, Ready1, RegWr} !== 3'b000) $display("FAIL reset_hold got=%b want=000", {Ready0, Ready1, RegWr});
        else pass_cnt++;
        Reset = 1'b0; Valid0 = 1'b0; Valid1 = 1'b0;
        tick();
    endtask

    task automatic test_single();
        wr_t e;
        pulse_reset();
        Valid0 = 1'b1; Addr0 = 5'd5; Data0 = 64'hDEAD_BEEF;
        #1;
        total_cnt++;
        if ({Ready0, Ready1} !== 2'b10) $display("FAIL single_ready got=%b want=10", {Ready0, Ready1});
        else pass_cnt++;
        exp_q.push_back('{a: 5'd5, d: 64'hDEAD_BEEF});
        tick();
        Valid0 = 1'b0;
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL single_write scoreboard empty");
        else begin
            e = exp_q.pop_front();
            if (RegWr !== 1'b1 || RW !== e.a || BusW !== e.d)
                $display("FAIL single_write got regwr=%b rw=%0d busw=%h want 1/%0d/%h", RegWr, RW, BusW, e.a, e.d);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (RegWr !== 1'b0) $display("FAIL single_strobe_len got=%b want=0", RegWr);
        else pass_cnt++;
        total_cnt++;
        if (regs[5] !== 64'hDEAD_BEEF) $display("FAIL single_regfile got=%h want=%h", regs[5], 64'hDEAD_BEEF);
        else pass_cnt++;
        // idle cycle: pointer must still favour requester 1 after the req-0 grant
        tick();
        Valid0 = 1'b1; Valid1 = 1'b1; Addr1 = 5'd6; Data1 = 64'h66;
        #1;
        total_cnt++;
        if ({Ready0, Ready1} !== 2'b01) $display("FAIL prio_hold got=%b want=01", {Ready0, Ready1});
        else pass_cnt++;
        Valid0 = 1'b0; Valid1 = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        wr_t e;
        int  g;
        pulse_reset();
        Valid0 = 1'b1; Valid1 = 1'b1; Addr0 = 5'd1; Addr1 = 5'd2;
        for (int k = 0; k < 4; k++) begin
            Data0 = 64'd10 + 64'(k);
            Data1 = 64'd20 + 64'(k);
            #1;
            g = k % 2;
            total_cnt++;
            if (Ready0 !== (g == 0) || Ready1 !== (g == 1))
                $display("FAIL contention_grant k=%0d got=%b%b want_grant=%0d", k, Ready0, Ready1, g);
            else pass_cnt++;
            exp_q.push_back(g == 0 ? '{a: 5'd1, d: Data0} : '{a: 5'd2, d: Data1});
            tick();
            total_cnt++;
            if (exp_q.size() == 0) $display("FAIL contention_write k=%0d scoreboard empty", k);
            else begin
                e = exp_q.pop_front();
                if (RegWr !== 1'b1 || RW !== e.a || BusW !== e.d)
                    $display("FAIL contention_write k=%0d got %b/%0d/%0d want 1/%0d/%0d", k, RegWr, RW, BusW, e.a, e.d);
                else pass_cnt++;
            end
        end
        Valid0 = 1'b0; Valid1 = 1'b0;
        tick();
    endtask

    task automatic test_zero_reg();
        pulse_reset();
        Valid1 = 1'b1; Addr1 = 5'd31; Data1 = 64'hBAD;
        for (int k = 0; k < 5; k++) begin
            #1;
            total_cnt++;
            if (Ready1 !== 1'b1) $display("FAIL zero_ready k=%0d got=%b want=1", k, Ready1);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (RegWr !== 1'b0 || RW !== 5'd0 || BusW !== 64'd0)
                $display("FAIL zero_nowrite k=%0d got %b/%0d/%h want 0/0/0", k, RegWr, RW, BusW);
            else pass_cnt++;
            if (k == 2) begin
                total_cnt++;
                if (DropCount !== 8'd3) $display("FAIL zero_count got=%0d want=3", DropCount);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (DropCount !== 8'd5) $display("FAIL zero_count5 got=%0d want=5", DropCount);
        else pass_cnt++;
        total_cnt++;
        if (DropCount_s !== 2'd3) $display("FAIL zero_saturate got=%0d want=3", DropCount_s);
        else pass_cnt++;
        Valid1 = 1'b0;
        tick();
    endtask

    task automatic test_same_addr();
        pulse_reset();
        Valid0 = 1'b1; Valid1 = 1'b1; Addr0 = 5'd7; Addr1 = 5'd7; Data0 = 64'd1; Data1 = 64'd2;
        #1;
        total_cnt++;
        if ({Ready0, Ready1} !== 2'b10) $display("FAIL race_first got=%b want=10", {Ready0, Ready1});
        else pass_cnt++;
        tick();
        Valid0 = 1'b0;
        @(negedge Clk); #1;
        total_cnt++;
        if (regs[7] !== 64'd1) $display("FAIL race_commit1 got=%0d want=1", regs[7]);
        else pass_cnt++;
        total_cnt++;
        if ({Ready0, Ready1} !== 2'b01) $display("FAIL race_second got=%b want=01", {Ready0, Ready1});
        else pass_cnt++;
        tick();
        Valid1 = 1'b0;
        @(negedge Clk); #1;
        total_cnt++;
        if (regs[7] !== 64'd2) $display("FAIL race_commit2 got=%0d want=2", regs[7]);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_mid_reset();
        pulse_reset();
        Valid0 = 1'b1; Valid1 = 1'b1; Addr0 = 5'd9; Addr1 = 5'd10; Data0 = 64'h90; Data1 = 64'hA0;
        tick();
        Reset = 1'b1;
        #1;
        total_cnt++;
        if ({Ready0, Ready1} !== 2'b00) $display("FAIL midrst_ready got=%b want=00", {Ready0, Ready1});
        else pass_cnt++;
        tick();
        total_cnt++;
        if (RegWr !== 1'b0 || DropCount !== 8'd0)
            $display("FAIL midrst_state got regwr=%b drop=%0d want 0/0", RegWr, DropCount);
        else pass_cnt++;
        Reset = 1'b0;
        #1;
        total_cnt++;
        if ({Ready0, Ready1} !== 2'b10) $display("FAIL midrst_prio got=%b want=10", {Ready0, Ready1});
        else pass_cnt++;
        tick();
        total_cnt++;
        if (RegWr !== 1'b1 || RW !== 5'd9 || BusW !== 64'h90)
            $display("FAIL midrst_resume got %b/%0d/%h want 1/9/90", RegWr, RW, BusW);
        else pass_cnt++;
        Valid0 = 1'b0; Valid1 = 1'b0;
        tick();
    endtask

    initial begin
        Reset = 1'b1; Valid0 = 1'b0; Valid1 = 1'b0;
        Addr0 = '0; Addr1 = '0; Data0 = '0; Data1 = '0;
        test_reset();
        test_single();
        test_contention();
        test_zero_reg();
        test_same_addr();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
